// File: rtl/bitplane_oe_scheduler.sv
// bitplane_oe_scheduler: times the HUB75 output-enable window of each latched bitplane, with dead time, dimming, tail blanking and overlap detection
package params_pkg;
  localparam int BRIGHTNESS_LEVELS = 8;
endpackage

module bitplane_oe_scheduler #(
  parameter int BASE_TIMEOUT = 23,
  parameter int BRIGHTNESS_LEVELS = params_pkg::BRIGHTNESS_LEVELS,
  parameter int DEADTIME = 2,
  parameter int DIM_WIDTH = 4,
  localparam int TW = $clog2(BASE_TIMEOUT) + BRIGHTNESS_LEVELS + 1
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         row_latch,
  input  logic [BRIGHTNESS_LEVELS-1:0] brightness_mask_active,
  input  logic                         mode,
  input  logic [DIM_WIDTH-1:0]         dimmer,
  output logic                         output_enable,
  output logic                         exceeded_overlap_time,
  output logic                         plane_done,
  output logic [TW-1:0]                timeout_value
);
  typedef enum logic [2:0] {IDLE, DEAD, ON, TAIL, DONE} state_t;
  state_t state, nxt;
  logic [TW-1:0] timer, nxt_timer, on_q, tail_q, src_on, src_tail, weight, t_cap, on_cap;
  logic [TW+DIM_WIDTH-1:0] prod;
  logic latch_q, lat_edge, busy, fin;
  int idx;
  // Capture arithmetic for the presented plane and next-phase selection; empty phases are skipped
  always_comb begin
    idx = 0;
    for (int i = 0; i < BRIGHTNESS_LEVELS; i++) if (brightness_mask_active[i]) idx = i;
    weight = brightness_mask_active == '0 ? '0 : mode ? TW'(1) : TW'(1) << idx;
    t_cap = TW'(BASE_TIMEOUT) * weight;
    prod = (TW+DIM_WIDTH)'(t_cap) * ((TW+DIM_WIDTH)'(dimmer) + (TW+DIM_WIDTH)'(1));
    on_cap = TW'(prod >> DIM_WIDTH);
    lat_edge = row_latch & ~latch_q;
    busy = state == DEAD || state == ON || state == TAIL;
    src_on = lat_edge ? on_cap : on_q;
    src_tail = lat_edge ? t_cap - on_cap : tail_q;
    fin = timer <= TW'(1);
    nxt = lat_edge ? (DEADTIME != 0 ? DEAD : src_on != '0 ? ON : src_tail != '0 ? TAIL : DONE)
        : state == DEAD && fin ? (src_on != '0 ? ON : src_tail != '0 ? TAIL : DONE)
        : state == ON && fin ? (src_tail != '0 ? TAIL : DONE)
        : state == TAIL && fin ? DONE
        : state == DONE ? IDLE : state;
    nxt_timer = !(lat_edge || nxt != state) ? timer - TW'(timer != '0)
              : nxt == DEAD ? TW'(DEADTIME) : nxt == ON ? src_on : nxt == TAIL ? src_tail : '0;
  end
  // Plane FSM with registered OE, done pulse and sticky overlap flag
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      on_q <= '0;
      tail_q <= '0;
      latch_q <= 1'b0;
      output_enable <= 1'b0;
      plane_done <= 1'b0;
      exceeded_overlap_time <= 1'b0;
      timeout_value <= '0;
    end else begin
      latch_q <= row_latch;
      state <= nxt;
      timer <= nxt_timer;
      output_enable <= nxt == ON;
      plane_done <= nxt == DONE;
      exceeded_overlap_time <= lat_edge && busy ? 1'b1 : nxt == DONE ? 1'b0 : exceeded_overlap_time;
      if (lat_edge) begin
        on_q <= on_cap;
        tail_q <= t_cap - on_cap;
        timeout_value <= t_cap;
      end
    end
  end
endmodule

// File: doc/bitplane_oe_scheduler.md
Name: bitplane_oe_scheduler

Overview:
Parametrised successor to brightness_timeout for the HUB75 row driver. On each row latch it times the output-enable window for the active bitplane. The window is binary-weighted or linear, and a global dimmer scales it. Dead-time blanking follows every latch, and a blanked tail keeps the plane period constant. It flags latch overlap and pulses plane_done to the row sequencer.

Parameters:
BASE_TIMEOUT, 23, clk_in cycles for the LSB plane (weight 1)
BRIGHTNESS_LEVELS, params_pkg::BRIGHTNESS_LEVELS, number of bitplanes (width of mask)
DEADTIME, 2, OE-off cycles after latch acceptance (0 allowed)
DIM_WIDTH, 4, width of global dimmer input
TW (localparam), $clog2(BASE_TIMEOUT)+BRIGHTNESS_LEVELS+1, timer/timeout width

Ports:
clk_in  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
row_latch  input  1  row latch strobe from row driver (level; rising edge sampled)
brightness_mask_active  input  BRIGHTNESS_LEVELS  one-hot active bitplane
mode  input  1  0 = binary weight 2^idx, 1 = linear weight 1
dimmer  input  DIM_WIDTH  global brightness; on fraction = (dimmer+1)/2^DIM_WIDTH
output_enable  output  1  active-high panel OE (registered)
exceeded_overlap_time  output  1  latch arrived before plane finished (registered, sticky)
plane_done  output  1  one-cycle pulse at end of plane period
timeout_value  output  TW  captured full plane period T (registered)

Behaviour:
- Reset (async): state IDLE, output_enable=0, exceeded_overlap_time=0, plane_done=0, timeout_value=0, timer=0, latch edge register=0.
- Latch edge: row_latch high at edge k and low at edge k-1. Only rising edges count; holding row_latch high is a single event.
- Capture at edge k:
  - idx = index of highest set bit of mask.
  - weight = mode ? 1 : (1<<idx); weight = 0 if mask == 0.
  - T = BASE_TIMEOUT*weight, TW bits, no overflow by construction.
  - on = (T*(dimmer+1)) >> DIM_WIDTH, computed at TW+DIM_WIDTH bits then truncated.
  - timeout_value <= T. Mask, mode and dimmer are ignored outside capture.
- States: IDLE -> DEAD -> ON -> TAIL -> DONE -> IDLE.
  - DEAD: DEADTIME cycles, OE=0. Skipped if DEADTIME=0.
  - ON: exactly `on` cycles with OE=1. Skipped if on=0.
  - TAIL: exactly T-on cycles with OE=0. Skipped if zero.
  - DONE: plane_done=1 for one cycle, then IDLE.
- Cycle-exact timing, with cycle k+1 the first after capture:
  - OE is high in cycles k+1+DEADTIME through k+DEADTIME+on.
  - plane_done is high in cycle k+1+DEADTIME+T.
  - mask=0 gives plane_done in cycle k+1+DEADTIME with OE never high.
- Overlap: a latch edge while state != IDLE:
  - Aborts the plane; no plane_done for the aborted plane.
  - exceeded_overlap_time <= 1.
  - Performs a fresh capture and re-enters DEAD, so OE is 0 from the next cycle.
- A latch edge in the same cycle as DONE is not an overlap. It is a normal capture, and plane_done still pulses.
- exceeded_overlap_time clears when plane_done pulses for a subsequently completed plane, or on reset.
- Timer: down-counter loaded on each state entry and decremented per cycle; the state advances when it reaches 1. No wrap-around: it is never decremented at 0.
- Reset mid-plane: OE drops asynchronously and the state returns to IDLE; the next plane needs a new latch edge.

Test Plan:
- Reset asserted mid-ON (mask=1<<7, mode 0) -> OE, plane_done, exceeded, timeout_value all 0 immediately; no OE until next latch edge.
- BASE=23, DEADTIME=2, mode 0, mask=1<<3, dimmer=15, latch at edge k:
  - timeout_value=184.
  - OE high exactly 184 cycles, k+3..k+186.
  - plane_done in cycle k+187; exceeded stays 0.
- mode 0, mask=1<<1, dimmer=7 -> T=46, OE high 23 cycles (k+3..k+25), 23 tail cycles, plane_done at k+49.
- mode 1, mask=1<<7, dimmer=15 -> T=23, OE 23 cycles; mask=0 -> OE never high, plane_done at k+3.
- Overlap, part 1: mode 0, mask=1<<7 (T=2944), second latch 100 cycles later with mask=1<<0, dimmer=15:
  - OE low the next cycle and exceeded=1.
  - timeout_value=23.
  - OE high 23 cycles after 2 dead cycles.
- Overlap, part 2: on that plane's plane_done, exceeded returns to 0.
- Held row_latch high 50 cycles -> single capture; latch edge coincident with DONE -> plane_done pulses, no exceeded, new plane starts.
